// File: rtl/chrono_scan_ctrl.sv
// rtl/chrono_scan_ctrl.sv - BCD MM:SS / HH:MM:SS chronometer with multiplexed 7-segment scan
// Optional macro DEBOUNCE_EN: filter each synchronised button/LOAD level over DEB_CYCLES.
module chrono_scan_ctrl #(
  parameter int CLK_HZ         = 50000000,
  parameter int TICK_HZ        = 1,
  parameter int SCAN_HZ        = 1000,
  parameter int N_DIGITS       = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter int DEB_CYCLES     = 500000
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  BTN_START,
  input  logic                  BTN_CLR,
  input  logic                  BTN_LAP,
  input  logic                  UP_DN,
  input  logic                  LOAD,
  input  logic [4*N_DIGITS-1:0] PRESET,
  output logic [6:0]            SEG,
  output logic                  DP,
  output logic [N_DIGITS-1:0]   DIG,
  output logic                  RUNNING,
  output logic                  DONE
);
  localparam int PRE_MAX   = CLK_HZ / TICK_HZ - 1;
  localparam int DWELL_MAX = CLK_HZ / SCAN_HZ - 1;
  localparam int PW        = (PRE_MAX > 0) ? $clog2(PRE_MAX + 1) : 1;
  localparam int DWW       = (DWELL_MAX > 0) ? $clog2(DWELL_MAX + 1) : 1;
  localparam bit HAS_HOURS = (N_DIGITS == 6);

  if (!(N_DIGITS == 4 || N_DIGITS == 6)) begin : g_bad_digits
    $error("chrono_scan_ctrl: N_DIGITS must be 4 or 6");
  end
  if (DEB_CYCLES < 1) begin : g_bad_deb
    $error("chrono_scan_ctrl: DEB_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {S_STOP, S_RUN, S_LAP, S_EXP} state_t;

  // Input conditioning: bit 0 start, 1 clr, 2 lap, 3 load
  logic [3:0] s1_q, s2_q, lvl_q, filt, pulse;

`ifdef DEBOUNCE_EN
  localparam int DBW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  logic [3:0]     deb_lvl_q;
  logic [DBW-1:0] deb_cnt_q [4];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      deb_lvl_q <= '0;
      for (int i = 0; i < 4; i++) deb_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (s2_q[i] == deb_lvl_q[i]) begin
          deb_cnt_q[i] <= '0;
        end else if (deb_cnt_q[i] == DBW'(DEB_CYCLES - 1)) begin
          deb_lvl_q[i] <= s2_q[i];
          deb_cnt_q[i] <= '0;
        end else begin
          deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end
  assign filt = deb_lvl_q;
`else
  assign filt = s2_q;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s1_q  <= '0;
      s2_q  <= '0;
      lvl_q <= '0;
    end else begin
      s1_q  <= {LOAD, BTN_LAP, BTN_CLR, BTN_START};
      s2_q  <= s1_q;
      lvl_q <= filt;
    end
  end
  assign pulse = filt & ~lvl_q;

  logic clr_p, load_p, start_p, lap_p;
  assign clr_p   = pulse[1];
  assign load_p  = pulse[3] & ~clr_p;
  assign start_p = pulse[0] & ~pulse[3] & ~clr_p;
  assign lap_p   = pulse[2] & ~pulse[0] & ~pulse[3] & ~clr_p;

  // Count is kept 24 bits wide; the hours byte stays zero in 4-digit builds.
  function automatic logic [23:0] bcd_step(input logic [23:0] v, input logic up);
    logic [23:0] r;
    logic        c;
    logic [3:0]  lim, d, hu, ht;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      lim = (i == 1 || i == 3) ? 4'd5 : 4'd9;
      d   = v[i*4 +: 4];
      if (c) begin
        if (up) begin
          if (d == lim) d = 4'd0;
          else begin d = d + 4'd1; c = 1'b0; end
        end else begin
          if (d == 4'd0) d = lim;
          else begin d = d - 4'd1; c = 1'b0; end
        end
      end
      r[i*4 +: 4] = d;
    end
    if (HAS_HOURS && c) begin
      hu = v[19:16];
      ht = v[23:20];
      if (up) begin
        if (ht == 4'd2 && hu == 4'd3) begin ht = 4'd0; hu = 4'd0; end
        else if (hu == 4'd9) begin hu = 4'd0; ht = ht + 4'd1; end
        else hu = hu + 4'd1;
      end else begin
        if (hu == 4'd0) begin hu = 4'd9; ht = ht - 4'd1; end
        else hu = hu - 4'd1;
      end
      r[23:16] = {ht, hu};
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_dec(input logic [3:0] v);
    case (v)
      4'd0: seg_dec = 7'h3F;
      4'd1: seg_dec = 7'h06;
      4'd2: seg_dec = 7'h5B;
      4'd3: seg_dec = 7'h4F;
      4'd4: seg_dec = 7'h66;
      4'd5: seg_dec = 7'h6D;
      4'd6: seg_dec = 7'h7D;
      4'd7: seg_dec = 7'h07;
      4'd8: seg_dec = 7'h7F;
      4'd9: seg_dec = 7'h6F;
      default: seg_dec = 7'h00;
    endcase
  endfunction

  logic [23:0] pre_san;
  always_comb begin
    pre_san = '0;
    pre_san[4*N_DIGITS-1:0] = PRESET;
    for (int i = 0; i < 6; i++)
      if (pre_san[i*4 +: 4] > 4'd9) pre_san[i*4 +: 4] = 4'd9;
    if (pre_san[7:4] > 4'd5)   pre_san[7:4]   = 4'd5;
    if (pre_san[15:12] > 4'd5) pre_san[15:12] = 4'd5;
    if (HAS_HOURS && pre_san[23:16] > 8'h23) pre_san[23:16] = 8'h23;
  end

  state_t        state_q, state_d;
  logic [23:0]   cnt_q, cnt_d, lap_q, lap_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          done_q, done_d, run, tick;

  assign run  = (state_q == S_RUN) || (state_q == S_LAP);
  assign tick = run && (pre_q == PW'(PRE_MAX));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lap_d   = lap_q;
    pre_d   = pre_q;
    done_d  = 1'b0;
    if (run) pre_d = tick ? '0 : pre_q + 1'b1;
    case (state_q)
      S_STOP: begin
        if (start_p) begin
          state_d = S_RUN;
          pre_d   = '0;
        end else if (load_p) begin
          cnt_d = pre_san;
          pre_d = '0;
        end
      end
      S_RUN: begin
        if (start_p) state_d = S_STOP;
        else if (lap_p) begin
          state_d = S_LAP;
          lap_d   = cnt_q;
        end
      end
      S_LAP: begin
        if (start_p)    state_d = S_STOP;
        else if (lap_p) state_d = S_RUN;
      end
      default: begin
        if (load_p) begin
          state_d = S_STOP;
          cnt_d   = pre_san;
          pre_d   = '0;
        end
      end
    endcase
    if (tick) begin
      if (UP_DN) cnt_d = bcd_step(cnt_q, 1'b1);
      else if (cnt_q == '0) begin
        done_d  = 1'b1;
        state_d = S_EXP;
      end else cnt_d = bcd_step(cnt_q, 1'b0);
    end
    // Clear overrides everything, including a tick landing in the same cycle.
    if (clr_p) begin
      state_d = S_STOP;
      cnt_d   = '0;
      pre_d   = '0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_STOP;
      cnt_q   <= '0;
      lap_q   <= '0;
      pre_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lap_q   <= lap_d;
      pre_q   <= pre_d;
      done_q  <= done_d;
    end
  end

  assign RUNNING = run;
  assign DONE    = done_q;

  // Scanner: SEG, DP and DIG are all registered from the same index.
  logic [DWW-1:0]      dw_q, dw_d;
  logic [2:0]          idx_q, idx_d;
  logic [23:0]         disp;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [N_DIGITS-1:0] dig_q, dig_d;

  always_comb begin
    dw_d  = dw_q + 1'b1;
    idx_d = idx_q;
    if (dw_q == DWW'(DWELL_MAX)) begin
      dw_d  = '0;
      idx_d = (idx_q == 3'(N_DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
    end
    disp  = (state_q == S_LAP) ? lap_q : cnt_q;
    seg_d = seg_dec(disp[{idx_q, 2'b00} +: 4]) ^ {7{SEG_ACTIVE_LOW}};
    dp_d  = ((idx_q == 3'd2) || (idx_q == 3'd4)) ^ SEG_ACTIVE_LOW;
    dig_d = ~(N_DIGITS'(1) << idx_q);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      dw_q  <= '0;
      idx_q <= '0;
      seg_q <= 7'h3F ^ {7{SEG_ACTIVE_LOW}};
      dp_q  <= SEG_ACTIVE_LOW;
      dig_q <= ~N_DIGITS'(1);
    end else begin
      dw_q  <= dw_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
      dig_q <= dig_d;
    end
  end

  assign SEG = seg_q;
  assign DP  = dp_q;
  assign DIG = dig_q;
endmodule

// File: tb/tb_chrono_scan_ctrl.sv
// tb/tb_chrono_scan_ctrl.sv - directed scoreboard bench for chrono_scan_ctrl (4- and 6-digit builds)
module tb_chrono_scan_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic btn_start = 1'b0, btn_clr = 1'b0, btn_lap = 1'b0, load = 1'b0, up_dn = 1'b1;
  logic [15:0] preset4 = '0;
  logic [23:0] preset6 = '0;
  logic [6:0]  seg4, seg6;
  logic        dp4, dp6, run4, run6, done4, done6;
  logic [3:0]  dig4;
  logic [5:0]  dig6;

  chrono_scan_ctrl #(.CLK_HZ(100), .TICK_HZ(10), .SCAN_HZ(50), .N_DIGITS(4),
                     .SEG_ACTIVE_LOW(1'b0), .DEB_CYCLES(4)) dut4 (
    .CLK(clk), .RST(rst_n), .BTN_START(btn_start), .BTN_CLR(btn_clr), .BTN_LAP(btn_lap),
    .UP_DN(up_dn), .LOAD(load), .PRESET(preset4), .SEG(seg4), .DP(dp4), .DIG(dig4),
    .RUNNING(run4), .DONE(done4));

  chrono_scan_ctrl #(.CLK_HZ(100), .TICK_HZ(10), .SCAN_HZ(50), .N_DIGITS(6),
                     .SEG_ACTIVE_LOW(1'b1), .DEB_CYCLES(4)) dut6 (
    .CLK(clk), .RST(rst_n), .BTN_START(btn_start), .BTN_CLR(btn_clr), .BTN_LAP(btn_lap),
    .UP_DN(up_dn), .LOAD(load), .PRESET(preset6), .SEG(seg6), .DP(dp6), .DIG(dig6),
    .RUNNING(run6), .DONE(done6));

  typedef struct { string tag; logic [23:0] val; } exp_t;
  exp_t sb[$];
  int n_checks = 0;
  int n_pass = 0;
  int done4_cnt = 0;

  always @(negedge clk) if (rst_n && done4) done4_cnt++;

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  function automatic logic [3:0] seg2bcd(input logic [6:0] s);
    case (s)
      7'h3F: return 4'd0;
      7'h06: return 4'd1;
      7'h5B: return 4'd2;
      7'h4F: return 4'd3;
      7'h66: return 4'd4;
      7'h6D: return 4'd5;
      7'h7D: return 4'd6;
      7'h07: return 4'd7;
      7'h7F: return 4'd8;
      7'h6F: return 4'd9;
      default: return 4'hE;
    endcase
  endfunction

  function automatic int idx6();
    int r;
    r = -1;
    for (int k = 0; k < 6; k++) if (!dig6[k]) r = k;
    return r;
  endfunction

  task automatic press(input logic [3:0] m);
    {load, btn_lap, btn_clr, btn_start} = m;
    @(negedge clk);
    {load, btn_lap, btn_clr, btn_start} = 4'b0000;
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic read_disp(input int which, output logic [23:0] v);
    logic [5:0] d;
    logic [6:0] s;
    int idx, nd;
    v  = '0;
    nd = (which == 6) ? 6 : 4;
    for (int c = 0; c < 2 * nd; c++) begin
      if (which == 6) begin d = dig6; s = ~seg6; end
      else begin d = {2'b11, dig4}; s = seg4; end
      idx = -1;
      for (int k = 0; k < 6; k++) if (!d[k]) idx = k;
      check("dig_one_low", 24'($countones(~d)), 24'd1);
      if (idx >= 0) v[idx*4 +: 4] = seg2bcd(s);
      @(negedge clk);
    end
  endtask

  task automatic expect_disp(input string tag, input logic [23:0] v);
    sb.push_back('{tag, v});
  endtask

  task automatic read_and_check(input int which);
    exp_t e;
    logic [23:0] v;
    read_disp(which, v);
    if (sb.size() == 0) begin
      n_checks++;
      $display("FAIL sb_underflow: observed display %h with no expectation queued", v);
    end else begin
      e = sb.pop_front();
      check(e.tag, v, e.val);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  int d0, cur, prev, st, ex;

  initial begin
    wait_n(3);
    check("rst_dig4", 24'(dig4), 24'hE);
    check("rst_seg4", 24'(seg4), 24'h3F);
    check("rst_dp4", 24'(dp4), 24'd0);
    check("rst_run4", 24'(run4), 24'd0);
    check("rst_done4", 24'(done4), 24'd0);
    check("rst_dig6", 24'(dig6), 24'h3E);
    check("rst_seg6", 24'(seg6), 24'h40);
    check("rst_dp6", 24'(dp6), 24'd1);
    rst_n = 1'b1;
    wait_n(2);

    // Start latency and 60 ticks up to 01:00
    press(4'b0001);
    wait_n(1);
    check("start_lat2", 24'(run4), 24'd0);
    wait_n(1);
    check("start_lat3", 24'(run4), 24'd1);
    wait_n(601);
    expect_disp("t1_0100", 24'h000100);
    read_and_check(4);
    check("t1_running", 24'(run4), 24'd1);
    press(4'b0010);
    wait_n(3);
    check("t1_clr_stop", 24'(run4), 24'd0);

    // Preset sanitising
    preset4 = 16'hF9A7;
    preset6 = 24'h990000;
    press(4'b1000);
    wait_n(2);
    expect_disp("san4", 24'h005957);
    read_and_check(4);
    expect_disp("san6", 24'h230000);
    read_and_check(6);

    // Up-count wrap at 59:59
    preset4 = 16'h5958;
    press(4'b1000);
    wait_n(2);
    press(4'b0001);
    wait_n(13);
    expect_disp("wrap_5959", 24'h005959);
    read_and_check(4);
    wait_n(2);
    expect_disp("wrap_0000", 24'h000000);
    read_and_check(4);
    check("wrap_running", 24'(run4), 24'd1);
    check("wrap_no_done", 24'(done4_cnt), 24'd0);
    press(4'b0010);
    wait_n(2);

    // Countdown expiry
    up_dn = 1'b0;
    preset4 = 16'h0002;
    preset6 = 24'h000002;
    press(4'b1000);
    wait_n(2);
    d0 = done4_cnt;
    press(4'b0001);
    wait_n(13);
    expect_disp("dn_0001", 24'h000001);
    read_and_check(4);
    wait_n(2);
    expect_disp("dn_0000", 24'h000000);
    read_and_check(4);
    check("dn_no_done_yet", 24'(done4_cnt - d0), 24'd0);
    wait_n(3);
    check("dn_done_once", 24'(done4_cnt - d0), 24'd1);
    check("dn_expired_run", 24'(run4), 24'd0);
    press(4'b0001);
    wait_n(30);
    check("exp_start_ign", 24'(run4), 24'd0);
    expect_disp("exp_hold", 24'h000000);
    read_and_check(4);
    check("exp_done_once", 24'(done4_cnt - d0), 24'd1);
    preset4 = 16'h0003;
    press(4'b1000);
    wait_n(2);
    check("exp_load_stop", 24'(run4), 24'd0);
    expect_disp("exp_load", 24'h000003);
    read_and_check(4);
    press(4'b0010);
    wait_n(2);

    // Lap freeze, release, then CLR+START on a tick
    up_dn = 1'b1;
    preset4 = 16'h0005;
    press(4'b1000);
    wait_n(2);
    press(4'b0001);
    wait_n(2);
    press(4'b0100);
    wait_n(18);
    expect_disp("lap_frozen", 24'h000005);
    read_and_check(4);
    check("lap_running", 24'(run4), 24'd1);
    press(4'b0100);
    wait_n(3);
    expect_disp("lap_live", 24'h000008);
    read_and_check(4);
    wait_n(18);
    press(4'b0011);
    wait_n(2);
    check("clr_tick_run", 24'(run4), 24'd0);
    expect_disp("clr_tick_cnt", 24'h000000);
    read_and_check(4);
    wait_n(20);
    expect_disp("clr_stays", 24'h000000);
    read_and_check(4);

    // Hours wrap and 6-digit scan
    preset4 = 16'h5959;
    preset6 = 24'h235959;
    press(4'b1000);
    wait_n(2);
    press(4'b0001);
    wait_n(10);
    press(4'b0001);
    wait_n(2);
    check("h_stopped", 24'(run6), 24'd0);
    expect_disp("h_wrap6", 24'h000000);
    read_and_check(6);
    expect_disp("h_wrap4", 24'h000000);
    read_and_check(4);
    cur = idx6();
    prev = cur;
    for (int b = 0; b < 4 && cur == prev; b++) begin
      @(negedge clk);
      cur = idx6();
    end
    st = cur;
    for (int k = 0; k < 12; k++) begin
      ex = (st + k / 2) % 6;
      check("walk_idx", 24'(idx6()), 24'(ex));
      check("walk_dp", 24'(dp6), (ex == 2 || ex == 4) ? 24'd0 : 24'd1);
      if (ex == 0) check("walk_seg0", 24'(seg6), 24'h40);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
